// File: rtl/shift_reg_sequencer_if.sv
// Bundle of request, serial-output and shift-register control signals for shift_reg_sequencer.
// The sequencer uses the slave modport; the requester/shift-register side uses master.
interface shift_reg_sequencer_if;
    logic [1:0] req;
    logic [3:0] data0;
    logic [3:0] data1;
    logic       stall;
    logic       sr_q0;
    logic       sr_load;
    logic       sr_ena;
    logic [3:0] sr_data;
    logic [1:0] gnt;
    logic       ser_out;
    logic       ser_valid;
    logic       done;
    logic       owner;
    logic       busy;

    modport master (
        output req, data0, data1, stall, sr_q0,
        input  sr_load, sr_ena, sr_data, gnt, ser_out, ser_valid, done, owner, busy
    );

    modport slave (
        input  req, data0, data1, stall, sr_q0,
        output sr_load, sr_ena, sr_data, gnt, ser_out, ser_valid, done, owner, busy
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Round-robin arbiter that loads the winner's word into an external right-shift register and streams it out.
// Latency: grant 1 cycle after req is seen; SHIFT_LEN+2 cycles per transaction plus stalled cycles.
// Backpressure: stall freezes the SHIFT phase only; requesters hold req until their gnt pulse.
module shift_reg_sequencer #(
    parameter int SHIFT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 areset_n,
    shift_reg_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] LAST = 2'(SHIFT_LEN - 1);

    logic [1:0] state;
    logic [1:0] count;
    logic       owner_q;
    logic       rr_pref;
    logic [3:0] word;
    logic       winner;

    // rr_pref names the requester that wins a tie; it flips away from each grant.
    always_comb begin
        winner = 1'b0;
        case (bus.req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = rr_pref;
            default: winner = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= IDLE;
            count   <= 2'd0;
            owner_q <= 1'b0;
            rr_pref <= 1'b0;
            word    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        word    <= winner ? bus.data1 : bus.data0;
                        owner_q <= winner;
                        rr_pref <= ~winner;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    count <= 2'd0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (!bus.stall) begin
                        count <= count + 2'd1;
                        if (count == LAST)
                            state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state so reset clears them without waiting for a clock.
    always_comb begin
        bus.sr_load   = (state == LOAD);
        bus.sr_data   = (state == LOAD) ? word : 4'd0;
        bus.gnt       = (state == LOAD) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        bus.sr_ena    = (state == SHIFT) && !bus.stall;
        bus.ser_valid = (state == SHIFT) && !bus.stall;
        bus.ser_out   = (state == SHIFT) && !bus.stall && bus.sr_q0;
        bus.done      = (state == DONE);
        bus.owner     = owner_q;
        bus.busy      = (state != IDLE);
    end
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural 4-bit right-shift register on sr_*.
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
module tb_shift_reg_sequencer;
    logic clk;
    logic areset_n;
    logic [3:0] sr;
    int vectors;
    int miscompares;
    int viol;
    logic [1:0] gv [0:3];
    logic [3:0] sd [0:3];
    int gt [0:3];
    int ng;

    shift_reg_sequencer_if bus ();

    shift_reg_sequencer #(.SHIFT_LEN(4)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial sr = 4'd0;
    always @(posedge clk) begin
        if (bus.sr_load)
            sr <= bus.sr_data;
        else if (bus.sr_ena)
            sr <= {1'b0, sr[3:1]};
    end
    assign bus.sr_q0 = sr[0];

    initial viol = 0;
    always @(negedge clk) if (bus.sr_load && bus.sr_ena) viol++;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        areset_n  = 1'b0;
        bus.req   = 2'b00;
        bus.stall = 1'b0;
        cyc;
        cyc;
        areset_n = 1'b1;
    endtask

    function automatic logic [12:0] outs;
        return {bus.sr_load, bus.sr_ena, bus.sr_data, bus.gnt, bus.ser_out,
                bus.ser_valid, bus.done, bus.owner, bus.busy};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        areset_n    = 1'b0;
        bus.req     = 2'b00;
        bus.data0   = 4'd0;
        bus.data1   = 4'd0;
        bus.stall   = 1'b0;
        #1;
        chk("reset_outputs", outs(), 13'd0);
        do_reset;

        // Basic transaction: data0=1011 emerges LSB first.
        bus.req = 2'b01; bus.data0 = 4'b1011; #1;
        chk("idle_not_busy", bus.busy, 1'b0);
        cyc; #1;
        chk("t1_load_gnt", bus.gnt, 2'b01);
        chk("t1_load_strobe", {bus.sr_load, bus.sr_ena}, 2'b10);
        chk("t1_load_data", bus.sr_data, 4'b1011);
        chk("t1_owner", bus.owner, 1'b0);
        bus.req = 2'b00;
        cyc; #1; chk("t1_bit0", {bus.ser_valid, bus.sr_ena, bus.ser_out}, 3'b111);
        cyc; #1; chk("t1_bit1", {bus.ser_valid, bus.sr_ena, bus.ser_out}, 3'b111);
        cyc; #1; chk("t1_bit2", {bus.ser_valid, bus.sr_ena, bus.ser_out}, 3'b110);
        cyc; #1; chk("t1_bit3", {bus.ser_valid, bus.sr_ena, bus.ser_out}, 3'b111);
        cyc; #1; chk("t1_done", {bus.done, bus.gnt, bus.ser_valid, bus.sr_load}, 5'b10000);
        cyc; #1; chk("t1_idle", {bus.done, bus.busy}, 2'b00);

        // Both requesting continuously: 01, 10, 01 at 7-cycle spacing.
        do_reset;
        bus.data0 = 4'h1; bus.data1 = 4'h2; bus.req = 2'b11;
        ng = 0;
        for (int k = 0; k < 4; k++) begin gv[k] = 2'b00; sd[k] = 4'd0; gt[k] = 0; end
        for (int i = 0; i < 25; i++) begin
            cyc; #1;
            if (bus.gnt != 2'b00 && ng < 4) begin
                gv[ng] = bus.gnt; sd[ng] = bus.sr_data; gt[ng] = i; ng++;
            end
        end
        bus.req = 2'b00;
        chk("rr_first", gv[0], 2'b01);
        chk("rr_second", gv[1], 2'b10);
        chk("rr_third", gv[2], 2'b01);
        chk("rr_second_data", sd[1], 4'h2);
        chk("rr_spacing_1", 16'(gt[1] - gt[0]), 16'd7);
        chk("rr_spacing_2", 16'(gt[2] - gt[1]), 16'd7);

        // Two stalled cycles after the second shift.
        do_reset;
        bus.req = 2'b01; bus.data0 = 4'b1011;
        cyc; #1; chk("st_load", bus.gnt, 2'b01);
        bus.req = 2'b00;
        cyc; #1; chk("st_bit0", {bus.ser_valid, bus.ser_out}, 2'b11);
        cyc; #1; chk("st_bit1", {bus.ser_valid, bus.ser_out}, 2'b11);
        cyc; bus.stall = 1'b1; #1;
        chk("st_hold0", {bus.ser_valid, bus.sr_ena, bus.ser_out, bus.busy, bus.done}, 5'b00010);
        cyc; #1;
        chk("st_hold1", {bus.ser_valid, bus.sr_ena, bus.ser_out, bus.busy, bus.done}, 5'b00010);
        cyc; bus.stall = 1'b0; #1;
        chk("st_bit2", {bus.ser_valid, bus.ser_out}, 2'b10);
        cyc; #1; chk("st_bit3", {bus.ser_valid, bus.ser_out, bus.done}, 3'b110);
        cyc; #1; chk("st_done", bus.done, 1'b1);
        cyc; #1; chk("st_idle", bus.busy, 1'b0);

        // Reset during the third shift aborts; a later req from requester 1 is served.
        bus.req = 2'b01; bus.data0 = 4'b1011;
        cyc; #1; chk("ab_load", bus.gnt, 2'b01);
        bus.req = 2'b00;
        cyc; #1;
        cyc; #1; chk("ab_bit1", {bus.ser_valid, bus.ser_out}, 2'b11);
        cyc; areset_n = 1'b0; #1;
        chk("ab_async_clear", outs(), 13'd0);
        cyc; #1; chk("ab_no_done", {bus.done, bus.busy}, 2'b00);
        areset_n = 1'b1; bus.req = 2'b10; bus.data1 = 4'b0110; #1;
        cyc; #1;
        chk("ab_gnt1", bus.gnt, 2'b10);
        chk("ab_data1", bus.sr_data, 4'b0110);
        chk("ab_owner1", bus.owner, 1'b1);
        bus.req = 2'b00;
        cyc; #1; chk("ab_bit0", {bus.ser_valid, bus.ser_out}, 2'b10);
        cyc; #1; chk("ab_bit1b", {bus.ser_valid, bus.ser_out}, 2'b11);
        cyc; #1; chk("ab_bit2", {bus.ser_valid, bus.ser_out}, 2'b11);
        cyc; #1; chk("ab_bit3", {bus.ser_valid, bus.ser_out}, 2'b10);
        cyc; #1; chk("ab_done", {bus.done, bus.owner}, 2'b11);

        // Captured word is immune to data/req changes; stall in LOAD is ignored.
        do_reset;
        bus.req = 2'b01; bus.data0 = 4'b1011;
        cyc; bus.stall = 1'b1; #1;
        chk("im_load_stall", {bus.sr_load, bus.sr_ena, bus.sr_data}, 6'b10_1011);
        cyc; bus.stall = 1'b0; bus.req = 2'b00; bus.data0 = 4'b0000; #1;
        chk("im_bit0", {bus.ser_valid, bus.ser_out}, 2'b11);
        cyc; bus.req = 2'b10; bus.data1 = 4'b1111; #1;
        chk("im_bit1", {bus.ser_valid, bus.ser_out}, 2'b11);
        cyc; #1; chk("im_bit2", {bus.ser_valid, bus.ser_out, bus.gnt}, 4'b1000);
        cyc; #1; chk("im_bit3", {bus.ser_valid, bus.ser_out}, 2'b11);
        bus.req = 2'b00;
        cyc; #1; chk("im_done", bus.done, 1'b1);
        cyc; #1;
        chk("load_ena_exclusive", 16'(viol), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 SHALL have parameter SHIFT_LEN, default 4, meaning shifts issued per transaction, legal range 1..4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port areset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  2  level request per requester; held until the matching gnt bit is seen.
REQ-005 SHALL have port data0  input  4  requester 0 load word.
REQ-006 SHALL have port data1  input  4  requester 1 load word.
REQ-007 SHALL have port stall  input  1  pauses shifting while high.
REQ-008 SHALL have port sr_q0  input  1  bit 0 of the controlled 4-bit right-shift register.
REQ-009 SHALL have port sr_load  output  1  synchronous load strobe to the shift register.
REQ-010 SHALL have port sr_ena  output  1  right-shift enable to the shift register.
REQ-011 SHALL have port sr_data  output  4  load word to the shift register.
REQ-012 SHALL have port gnt  output  2  one-hot grant pulse.
REQ-013 SHALL have port ser_out  output  1  serial data bit; meaningful only when ser_valid is 1.
REQ-014 SHALL have port ser_valid  output  1  marks a valid serial bit.
REQ-015 SHALL have port done  output  1  end-of-transaction pulse.
REQ-016 SHALL have port owner  output  1  index of the requester currently or last served.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SHIFT and DONE, with all state held in registers.
REQ-019 IDLE: when req is nonzero at a clock edge, SHALL select a winner, capture its data word into an internal register, set owner and go to LOAD; otherwise SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: a single request wins; when both request, the requester not granted last wins; after reset, requester 0 wins.
REQ-021 LOAD (exactly 1 cycle): sr_load=1, sr_data=captured word, gnt[owner]=1, then go to SHIFT with shift count=0.
REQ-022 SHIFT: sr_ena = ser_valid = NOT stall; ser_out = sr_q0 (pre-shift bit, combinational); count increments on each cycle in which stall=0.
REQ-023 SHIFT SHALL go to DONE on the unstalled cycle where count = SHIFT_LEN-1; a stalled cycle SHALL hold state and count.
REQ-024 DONE (exactly 1 cycle): done=1, then go to IDLE; req SHALL NOT be sampled in DONE.
REQ-025 Transaction length SHALL be SHIFT_LEN+2 cycles plus stalled cycles; minimum spacing between grants SHALL be SHIFT_LEN+3 cycles.
REQ-026 sr_load and sr_ena SHALL never both be 1; gnt, done and sr_load SHALL be 0 outside their states.
REQ-027 sr_data SHALL be 0 outside LOAD; ser_out SHALL be 0 whenever ser_valid=0.
REQ-028 Changes on req or data during LOAD, SHIFT or DONE SHALL NOT affect the transaction in progress.
REQ-029 stall in IDLE, LOAD or DONE SHALL be ignored.

Reset
REQ-030 When areset_n=0, the block SHALL immediately enter IDLE and force count=0, owner=0, sr_load=sr_ena=gnt=done=ser_valid=busy=0 and sr_data=0, with the round-robin pointer set to favour requester 0.
REQ-031 Assertion of reset mid-transaction SHALL abort the transaction with no done pulse; the first req seen after release SHALL be served normally.

Verification
REQ-032 req=01, data0=4'b1011, SHIFT_LEN=4, stall=0 -> gnt=01 with sr_load and sr_data=1011 in LOAD; ser_out 1,1,0,1 on 4 consecutive cycles; done on the next cycle.
REQ-033 req=11 held continuously after reset -> grants in order 01, 10, 01, each 7 cycles apart.
REQ-034 stall=1 for 2 cycles after the second shift -> ser_valid and sr_ena low for those 2 cycles, all 4 bits still delivered, done 2 cycles later than in REQ-032.
REQ-035 areset_n pulsed low during SHIFT after 2 bits -> all outputs 0 and busy=0 at once, no done; req=10 after release -> gnt=10.
REQ-036 req=01 with data0 changed to 4'b0000 during SHIFT -> serial bits unchanged from the captured word; sr_load and sr_ena never both high throughout.
